// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM state
// encoding, port index constants and a small port helper.
package mem_bus_arbiter_pkg;

  // Arbiter FSM states. The values are fixed so software/debug views
  // of the state register stay stable across builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_e;

  // Port indices: port 0 is the CPU, port 1 the secondary master.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // The port that is not p; used to hand a tie to whoever was not served last.
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_select.sv
// Winner selection for the memory bus arbiter. Purely combinational:
// a lone request always wins; on a tie the port that was not served
// last wins. Feeding a constant PORT1 as the pointer turns this into
// fixed priority for port 0.
module mem_arb_select
  import mem_bus_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic winner_o,
  output logic valid_o
);

  // Pick the winning port index and flag that a winner exists.
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = PORT0;
    if (req0_i && req1_i) begin
      winner_o = other_port(last_i);
    end else if (req1_i) begin
      winner_o = PORT1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory/IO bus arbiter. A request seen in IDLE is granted in
// the same cycle (o_gnt is a one-cycle pulse), its command is driven on
// the bus for exactly one ACCESS cycle, and reads collect i_mem_data in
// RDATA and pulse o_rvalid on the following cycle.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; without it port 0 always wins a tie.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_wr0,
  input  logic                  i_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [RAM_WIDTH-1:0]  i_data0,
  input  logic [RAM_WIDTH-1:0]  i_data1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [RAM_WIDTH-1:0]  o_rdata0,
  output logic [RAM_WIDTH-1:0]  o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [RAM_WIDTH-1:0]  o_data,
  output logic                  o_wr,
  output logic                  o_rd,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  output logic                  o_busy
);

  arb_state_e            state_q;
  logic                  port_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RAM_WIDTH-1:0]  data_q;
  logic                  wr_q;
  logic                  rd_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic [RAM_WIDTH-1:0]  rdata0_q;
  logic [RAM_WIDTH-1:0]  rdata1_q;

  logic                  last_ptr;
  logic                  sel_port;
  logic                  sel_valid;
  logic                  take;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]  sel_data;

  mem_arb_select u_select (
    .req0_i   (i_req0),
    .req1_i   (i_req1),
    .last_i   (last_ptr),
    .winner_o (sel_port),
    .valid_o  (sel_valid)
  );

  // A grant only happens in IDLE and never while reset is being applied,
  // so a request held across reset is granted on the first free cycle.
  assign take = (state_q == IDLE) && !i_rst && sel_valid;

  // Route the winning port's command fields toward the command registers.
  always_comb begin
    sel_wr   = i_wr0;
    sel_addr = i_addr0;
    sel_data = i_data0;
    if (sel_port == PORT1) begin
      sel_wr   = i_wr1;
      sel_addr = i_addr1;
      sel_data = i_data1;
    end
  end

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Remember which port won the latest grant so the other one wins the next tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= PORT1;
    end else if (take) begin
      last_q <= sel_port;
    end
  end

  assign last_ptr = last_q;
`else
  // Fixed priority: pretending port 1 was always served last hands every tie to port 0.
  assign last_ptr = PORT1;
`endif

  // Arbiter FSM with registered bus strobes, read data and rvalid pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      port_q    <= PORT0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      // Strobes and rvalid are single-cycle pulses unless set below.
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            port_q  <= sel_port;
            addr_q  <= sel_addr;
            data_q  <= sel_data;
            wr_q    <= sel_wr;
            rd_q    <= !sel_wr;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // wr_q still holds this transaction's direction during ACCESS.
          state_q <= wr_q ? IDLE : RDATA;
        end
        RDATA: begin
          // Memory answers one cycle after the read strobe; latch it for the winner.
          if (port_q == PORT0) begin
            rdata0_q  <= i_mem_data;
            rvalid0_q <= 1'b1;
          end else begin
            rdata1_q  <= i_mem_data;
            rvalid1_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt0    = take && (sel_port == PORT0);
  assign o_gnt1    = take && (sel_port == PORT1);
  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_wr      = wr_q;
  assign o_rd      = rd_q;
  assign o_rvalid0 = rvalid0_q;
  assign o_rvalid1 = rvalid1_q;
  assign o_rdata0  = rdata0_q;
  assign o_rdata1  = rdata1_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized request traffic, all checked every cycle against a
// transaction-level timing model. Honours MEM_ARB_RR_EN like the design.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int AW   = 11;
  localparam int RW   = 16;
  localparam int NCYC = 4096;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req0 = 1'b0, i_req1 = 1'b0;
  logic          i_wr0 = 1'b0, i_wr1 = 1'b0;
  logic [AW-1:0] i_addr0 = '0, i_addr1 = '0;
  logic [RW-1:0] i_data0 = '0, i_data1 = '0;
  logic [RW-1:0] i_mem_data;
  logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_wr, o_rd, o_busy;
  logic [RW-1:0] o_rdata0, o_rdata1, o_data;
  logic [AW-1:0] o_addr;

  always #5 i_clk = ~i_clk;

  mem_bus_arbiter #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_req1(i_req1), .i_wr0(i_wr0), .i_wr1(i_wr1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_data0(i_data0), .i_data1(i_data1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_addr(o_addr), .o_data(o_data),
    .o_wr(o_wr), .o_rd(o_rd), .i_mem_data(i_mem_data), .o_busy(o_busy)
  );

  // Unwritten locations hold a fixed pattern; 0x400 (peripheral space) reads 0xBEEF.
  function automatic logic [RW-1:0] init_fn(input logic [AW-1:0] a);
    logic [31:0] h;
    if (a == 11'h400) return 16'hBEEF;
    h = 32'(a) * 32'd40503 ^ 32'h5A5A;
    return h[RW-1:0];
  endfunction

  // Memory/IO wrapper: writes on o_wr, returns read data one cycle later.
  logic [RW-1:0] env_mem [NCYC/2];
  bit            env_vld [NCYC/2];
  logic [RW-1:0] mem_q = '0;
  always @(posedge i_clk) begin
    if (o_wr) begin
      env_mem[o_addr] <= o_data;
      env_vld[o_addr] <= 1'b1;
    end
    mem_q <= env_vld[o_addr] ? env_mem[o_addr] : init_fn(o_addr);
  end
  assign i_mem_data = mem_q;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each grant at cycle g schedules: command on the bus at g+1, and for a
  // read the data/rvalid at g+3; the arbiter is free again at g+2 (write)
  // or g+3 (read). Reset wipes everything scheduled after it.
  logic [RW-1:0] model_mem [NCYC/2];
  bit            model_vld [NCYC/2];
  bit            sch_cmd [NCYC], sch_wr [NCYC], sch_rd [NCYC], sch_rv0 [NCYC], sch_rv1 [NCYC];
  logic [AW-1:0] sch_addr [NCYC];
  logic [RW-1:0] sch_data [NCYC], sch_rdat [NCYC];
  logic [AW-1:0] m_addr = '0;
  logic [RW-1:0] m_data = '0, m_rdata0 = '0, m_rdata1 = '0;
  int            free_at = 0;
  bit            last = 1'b1;
  bit            gseen0 = 1'b0, gseen1 = 1'b0;
  int            txn = 0;

  always @(negedge i_clk) begin : model
    bit g, w, gw;
    logic [AW-1:0] ga;
    logic [RW-1:0] gd;
    if (sch_cmd[cyc]) begin
      m_addr = sch_addr[cyc];
      m_data = sch_data[cyc];
    end
    if (sch_rv0[cyc]) m_rdata0 = sch_rdat[cyc];
    if (sch_rv1[cyc]) m_rdata1 = sch_rdat[cyc];
    g = (cyc >= free_at) && !i_rst && (i_req0 || i_req1);
    w = (i_req0 && i_req1) ? (RR ? !last : 1'b0) : i_req1;
    if (cmp_en) begin
      chk("gnt0", o_gnt0, g && !w);
      chk("gnt1", o_gnt1, g && w);
      chk("busy", o_busy, cyc < free_at);
      chk("wr", o_wr, sch_wr[cyc]);
      chk("rd", o_rd, sch_rd[cyc]);
      chk("addr", o_addr, m_addr);
      chk("data", o_data, m_data);
      chk("rvalid0", o_rvalid0, sch_rv0[cyc]);
      chk("rvalid1", o_rvalid1, sch_rv1[cyc]);
      chk("rdata0", o_rdata0, m_rdata0);
      chk("rdata1", o_rdata1, m_rdata1);
    end
    gseen0 = g && !w;
    gseen1 = g && w;
    if (g) begin
      gw = w ? i_wr1 : i_wr0;
      ga = w ? i_addr1 : i_addr0;
      gd = w ? i_data1 : i_data0;
      sch_cmd[cyc+1]  = 1'b1;
      sch_addr[cyc+1] = ga;
      sch_data[cyc+1] = gd;
      if (gw) begin
        sch_wr[cyc+1] = 1'b1;
        model_mem[ga] = gd;
        model_vld[ga] = 1'b1;
        free_at = cyc + 2;
      end else begin
        sch_rd[cyc+1] = 1'b1;
        sch_rdat[cyc+3] = model_vld[ga] ? model_mem[ga] : init_fn(ga);
        if (w) sch_rv1[cyc+3] = 1'b1;
        else   sch_rv0[cyc+3] = 1'b1;
        free_at = cyc + 3;
      end
      last = w;
      txn++;
      $display("txn %0d cycle %0d: port%0d %s addr=0x%03h data=0x%04h",
               txn, cyc, w, gw ? "write" : "read ", ga, gd);
    end
    if (i_rst) begin
      for (int k = 1; k <= 3; k++) begin
        sch_cmd[cyc+k] = 1'b0; sch_wr[cyc+k] = 1'b0; sch_rd[cyc+k] = 1'b0;
        sch_rv0[cyc+k] = 1'b0; sch_rv1[cyc+k] = 1'b0;
      end
      m_addr = '0; m_data = '0; m_rdata0 = '0; m_rdata1 = '0;
      free_at = cyc + 1;
      last = 1'b1;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  initial begin : stim
    int seq [4];
    int ng;
    // Reset state
    step();
    cmp_en = 1'b1;
    mid();
    chk("rst_busy", o_busy, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_rdata0", o_rdata0, 0);
    chk("rst_wr", o_wr, 0);
    step(); i_rst = 1'b0;

    // Port 0 write 0x005 <- 0x1234
    step(); i_req0 = 1; i_wr0 = 1; i_addr0 = 11'h005; i_data0 = 16'h1234;
    mid(); chk("w_gnt0", o_gnt0, 1);
    step(); i_req0 = 0;
    mid(); chk("w_wr", o_wr, 1); chk("w_addr", o_addr, 11'h005); chk("w_data", o_data, 16'h1234);
    step();
    mid(); chk("w_idle", o_busy, 0); chk("w_wr_off", o_wr, 0);

    // Port 1 read 0x005
    step(); i_req1 = 1; i_wr1 = 0; i_addr1 = 11'h005; i_data1 = '0;
    mid(); chk("r_gnt1", o_gnt1, 1);
    step(); i_req1 = 0;
    mid(); chk("r_rd", o_rd, 1); chk("r_wr", o_wr, 0);
    step();
    mid(); chk("r_rv_early", o_rvalid1, 0);
    step();
    mid(); chk("r_rvalid1", o_rvalid1, 1); chk("r_rdata1", o_rdata1, 16'h1234);

    // Port 0 read of peripheral 0x400
    step(); i_req0 = 1; i_wr0 = 0; i_addr0 = 11'h400;
    mid(); chk("p_gnt0", o_gnt0, 1);
    step(); i_req0 = 0;
    mid(); chk("p_rd", o_rd, 1); chk("p_addr", o_addr, 11'h400);
    step(); step();
    mid(); chk("p_rvalid0", o_rvalid0, 1); chk("p_rdata0", o_rdata0, 16'hBEEF);

    // Both ports writing continuously
    step();
    i_req0 = 1; i_wr0 = 1; i_addr0 = 11'h010; i_data0 = 16'hA0A0;
    i_req1 = 1; i_wr1 = 1; i_addr1 = 11'h011; i_data1 = 16'hB1B1;
    ng = 0;
    for (int t = 0; t < 20 && ng < 4; t++) begin
      mid();
      if (o_gnt0) begin seq[ng] = 0; ng++; end
      else if (o_gnt1) begin seq[ng] = 1; ng++; end
      step();
    end
    i_req0 = 0; i_req1 = 0;
    chk("arb_count", ng, 4);
    for (int k = 0; k < ng; k++) chk("arb_seq", seq[k], RR ? ((k % 2 == 0) ? 1 : 0) : 0);

    // Reset during RDATA of a read
    step(); step();
    step(); i_req0 = 1; i_wr0 = 0; i_addr0 = 11'h007;
    mid(); chk("a_gnt0", o_gnt0, 1);
    step(); i_req0 = 0;
    step(); i_rst = 1;
    mid(); chk("a_busy", o_busy, 1);
    step(); i_rst = 0; i_req1 = 1; i_wr1 = 1; i_addr1 = 11'h009; i_data1 = 16'h0055;
    mid();
    chk("a_rvalid0", o_rvalid0, 0); chk("a_addr", o_addr, 0); chk("a_data", o_data, 0);
    chk("a_rdata0", o_rdata0, 0); chk("a_busy0", o_busy, 0); chk("a_gnt1", o_gnt1, 1);
    step(); i_req1 = 0;
    mid(); chk("a_wr", o_wr, 1); chk("a_waddr", o_addr, 11'h009);
    step();

    // Request raised in ACCESS and dropped before IDLE
    step(); i_req0 = 1; i_wr0 = 0; i_addr0 = 11'h003;
    mid(); chk("d_gnt0", o_gnt0, 1);
    step(); i_req0 = 0; i_req1 = 1; i_wr1 = 1; i_addr1 = 11'h022; i_data1 = 16'h0077;
    mid(); chk("d_gnt1_acc", o_gnt1, 0);
    step(); i_req1 = 0;
    mid(); chk("d_gnt1_rd", o_gnt1, 0); chk("d_wr", o_wr, 0);
    step();
    mid(); chk("d_gnt1_idle", o_gnt1, 0); chk("d_wr2", o_wr, 0); chk("d_rd2", o_rd, 0);
    step();
    mid(); chk("d_addr", o_addr, 11'h003); chk("d_busy", o_busy, 0);

    // Randomized traffic with occasional resets and dropped requests
    for (int n = 0; n < 1500; n++) begin
      step();
      i_rst = ($urandom_range(0, 63) == 0);
      if (i_req0 && (gseen0 || $urandom_range(0, 15) == 0)) begin
        i_req0 = 0;
      end else if (!i_req0 && $urandom_range(0, 2) == 0) begin
        i_req0 = 1; i_wr0 = 1'($urandom); i_addr0 = AW'($urandom); i_data0 = RW'($urandom);
      end
      if (i_req1 && (gseen1 || $urandom_range(0, 15) == 0)) begin
        i_req1 = 0;
      end else if (!i_req1 && $urandom_range(0, 2) == 0) begin
        i_req1 = 1; i_wr1 = 1'($urandom); i_addr1 = AW'($urandom); i_data1 = RW'($urandom);
      end
    end
    step(); i_rst = 0; i_req0 = 0; i_req1 = 0;
    for (int n = 0; n < 5; n++) step();
    mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: RAM_WIDTH, default 16, data width; ADDR_WIDTH, default 11, address width matching the memory/peripheral address bus.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_req0/i_req1  input  1  access request from port 0/1 (port 0 = CPU, port 1 = secondary master).
REQ-005 i_wr0/i_wr1  input  1  1 = write, 0 = read; qualifies the matching request.
REQ-006 i_addr0/i_addr1  input  ADDR_WIDTH  request address.
REQ-007 i_data0/i_data1  input  RAM_WIDTH  write data.
REQ-008 o_gnt0/o_gnt1  output  1  one-cycle pulse: command accepted.
REQ-009 o_rvalid0/o_rvalid1  output  1  one-cycle pulse: o_rdata0/o_rdata1 holds read data.
REQ-010 o_rdata0/o_rdata1  output  RAM_WIDTH  read data, held until the next rvalid on that port.
REQ-011 o_addr, o_data, o_wr, o_rd  output  ADDR_WIDTH/RAM_WIDTH/1/1  command to the memory/IO wrapper.
REQ-012 i_mem_data  input  RAM_WIDTH  read data returned by the memory/IO wrapper one cycle after o_rd.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, RDATA.
REQ-015 In IDLE with any request asserted, the block SHALL select a winner, register its wr/addr/data, pulse the winner's o_gnt in that same cycle, and move to ACCESS.
REQ-016 In ACCESS the block SHALL drive the registered command for exactly one cycle: o_wr=1 for writes, o_rd=1 for reads; o_wr and o_rd SHALL never both be 1.
REQ-017 From ACCESS a write SHALL return to IDLE; a read SHALL go to RDATA.
REQ-018 In RDATA the block SHALL capture i_mem_data into the winner's o_rdata register, pulse its o_rvalid on the following cycle, and return to IDLE.
REQ-019 Latency: write gnt to o_wr = 1 cycle; read gnt to rvalid = 3 cycles; minimum spacing between grants is 2 cycles (write) or 3 cycles (read).
REQ-020 Requests arriving outside IDLE SHALL be ignored until IDLE; a requester SHALL hold req/wr/addr/data stable until its gnt.
REQ-021 A request deasserted before gnt SHALL be dropped without any memory access.
REQ-022 Outside ACCESS, o_wr=o_rd=0 and o_addr/o_data SHALL hold the last command.
REQ-023 Addresses with the top bit set (peripheral space) SHALL be treated identically to memory addresses.

Reset
REQ-024 On i_rst: state=IDLE, all o_gnt/o_rvalid/o_wr/o_rd/o_busy=0, o_addr/o_data/o_rdata=0, last-served pointer=port 1.
REQ-025 Reset in ACCESS or RDATA SHALL abort the transaction: no rvalid, no further strobe.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not last served SHALL win, and the pointer SHALL update on each grant.
REQ-027 Macro MEM_ARB_RR_EN undefined: fixed priority, port 0 always wins on simultaneous requests; pointer logic absent.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RDATA=2'd2) and port index constants.
REQ-029 Winner selection SHALL be one sub-module, mem_arb_select (inputs: two requests, last-served pointer; output: winner index, valid).

Verification
REQ-030 Port 0 write addr 0x005 data 0x1234 -> gnt0 at cycle 0, o_wr=1/o_addr=0x005/o_data=0x1234 at cycle 1, idle at cycle 2.
REQ-031 Port 1 read of addr 0x005 after REQ-030 -> o_rd=1 at cycle 1, o_rvalid1=1 with o_rdata1=0x1234 at cycle 3.
REQ-032 Both ports request continuously (writes) with MEM_ARB_RR_EN -> grants alternate 1,0,1,0; without the macro -> all grants to port 0.
REQ-033 Port 0 read of 0x400 (peripheral) with i_mem_data=0xBEEF -> o_rvalid0 with o_rdata0=0xBEEF; o_rd never coincides with o_wr.
REQ-034 i_rst asserted in the RDATA cycle of a read -> no rvalid, all outputs 0 next cycle, a new request is granted immediately after reset release.
REQ-035 Request raised during ACCESS and dropped before IDLE -> no gnt and no memory strobe.
